// File: rtl/ring_cnt_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ring_cnt_pkg: ring mode constants and index-to-pattern helpers.  rev 1.0
//------------------------------------------------------------------------------
package ring_cnt_pkg;

    localparam int MODE_ONEHOT  = 0;
    localparam int MODE_JOHNSON = 1;
    localparam int RING_MAX_W   = 64;

    function automatic int num_states(input int width, input int mode);
        return (mode == MODE_JOHNSON) ? 2 * width : width;
    endfunction

    // Bits at and above width are always zero; callers truncate to their ring width.
    function automatic logic [RING_MAX_W-1:0] idx_to_pattern(input int k, input int width,
                                                             input int mode);
        logic [RING_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (i < width) begin
                if (mode == MODE_JOHNSON) begin
                    p[i] = (k <= width) ? (i < k) : (i >= k - width);
                end else begin
                    p[i] = (i == k);
                end
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_cnt_param_chk.sv
`default_nettype none
//------------------------------------------------------------------------------
// ring_cnt_chk: flags an illegal ring pattern or an out/pos mismatch.  rev 1.0
//------------------------------------------------------------------------------
module ring_cnt_chk
    import ring_cnt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int IW    = 3
)(
    input  logic [WIDTH-1:0] out_i,
    input  logic [IW-1:0]    pos_i,
    output logic             illegal_o
);

    localparam int NS = num_states(WIDTH, MODE);

    logic [WIDTH-2:0] w_trans;
    logic [WIDTH-1:0] w_exp_pat;
    logic             w_ring_ok;
    logic             w_pos_ok;

    // A legal Johnson word has at most one boundary between adjacent unequal bits.
    assign w_trans   = out_i[WIDTH-2:0] ^ out_i[WIDTH-1:1];
    assign w_ring_ok = (MODE == MODE_JOHNSON) ? ((w_trans & (w_trans - 1'b1)) == '0)
                                              : $onehot(out_i);
    assign w_exp_pat = WIDTH'(idx_to_pattern(int'(pos_i), WIDTH, MODE));
    assign w_pos_ok  = (int'(pos_i) < NS) && (out_i == w_exp_pat);
    assign illegal_o = !w_ring_ok || !w_pos_ok;

endmodule
`default_nettype wire

// File: rtl/ring_cnt_param.sv
`default_nettype none
//------------------------------------------------------------------------------
// ring_cnt_param: one-hot / Johnson ring counter with load, wrap and recovery.
// rev 1.0
//------------------------------------------------------------------------------
module ring_cnt_param
    import ring_cnt_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MODE      = 0,
    parameter  int RESET_POS = 0,
    localparam int NS        = num_states(WIDTH, MODE),
    localparam int IW        = $clog2(NS)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [IW-1:0]    load_idx,
    output logic [WIDTH-1:0] out,
    output logic [IW-1:0]    pos,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] C_RESET_PAT = WIDTH'(idx_to_pattern(RESET_POS, WIDTH, MODE));
    localparam logic [IW-1:0]    C_RESET_POS = IW'(RESET_POS);
    localparam logic [IW-1:0]    C_LAST_POS  = IW'(NS - 1);
    localparam logic             C_TWIST     = (MODE == MODE_JOHNSON) ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] out_q, out_d;
    logic [IW-1:0]    pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             w_illegal;
    logic             w_load_ok;

    assign out  = out_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;
    assign err  = err_q;

    // Checks the visible ring word so any corruption of it is caught.
    ring_cnt_chk #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .IW    (IW)
    ) u_chk (
        .out_i     (out),
        .pos_i     (pos_q),
        .illegal_o (w_illegal)
    );

    assign w_load_ok = (int'(load_idx) < NS);

    always_comb begin
        out_d  = out;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (w_illegal) begin
            out_d = C_RESET_PAT;
            pos_d = C_RESET_POS;
            err_d = 1'b1;
        end else if (load) begin
            if (w_load_ok) begin
                out_d = WIDTH'(idx_to_pattern(int'(load_idx), WIDTH, MODE));
                pos_d = load_idx;
            end else begin
                err_d = 1'b1;
            end
        end else if (enable) begin
            if (dir) begin
                out_d  = {out[WIDTH-2:0], out[WIDTH-1] ^ C_TWIST};
                pos_d  = (pos_q == C_LAST_POS) ? '0 : pos_q + 1'b1;
                wrap_d = (pos_q == C_LAST_POS);
            end else begin
                out_d  = {out[0] ^ C_TWIST, out[WIDTH-1:1]};
                pos_d  = (pos_q == '0) ? C_LAST_POS : pos_q - 1'b1;
                wrap_d = (pos_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= C_RESET_PAT;
            pos_q  <= C_RESET_POS;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_cnt_param.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ring_cnt_param: scoreboard bench over one-hot and Johnson instances.  rev 1.0
//------------------------------------------------------------------------------
module tb_ring_cnt_param;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] o;
        logic [2:0] p;
        logic       w;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dir = 1'b1;
    logic [2:0] load_idx = '0;
    logic [2:0] en = '0;
    logic [2:0] ld = '0;

    logic [7:0] out0;
    logic [3:0] out1;
    logic [4:0] out2;
    logic [2:0] pos0, pos1, pos2;
    logic       wrap0, wrap1, wrap2;
    logic       err0, err1, err2;

    int W_A[3]  = '{8, 4, 5};
    int M_A[3]  = '{0, 1, 0};
    int RP_A[3] = '{0, 0, 2};
    int midx[3];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_cnt_param #(.WIDTH(8), .MODE(0), .RESET_POS(0)) u0 (
        .clk(clk), .reset(reset), .enable(en[0]), .dir(dir), .load(ld[0]),
        .load_idx(load_idx), .out(out0), .pos(pos0), .wrap(wrap0), .err(err0));
    ring_cnt_param #(.WIDTH(4), .MODE(1), .RESET_POS(0)) u1 (
        .clk(clk), .reset(reset), .enable(en[1]), .dir(dir), .load(ld[1]),
        .load_idx(load_idx), .out(out1), .pos(pos1), .wrap(wrap1), .err(err1));
    ring_cnt_param #(.WIDTH(5), .MODE(0), .RESET_POS(2)) u2 (
        .clk(clk), .reset(reset), .enable(en[2]), .dir(dir), .load(ld[2]),
        .load_idx(load_idx), .out(out2), .pos(pos2), .wrap(wrap2), .err(err2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int w, input int m, input int k);
        logic [7:0] one;
        one = 8'd1;
        if (m == 0) return one << k;
        if (k <= w) return (one << k) - one;
        return ((one << w) - one) & ~((one << (k - w)) - one);
    endfunction

    function automatic int ns_of(input int j);
        return (M_A[j] == 1) ? 2 * W_A[j] : W_A[j];
    endfunction

    function automatic exp_t mk(input int j, input logic w, input logic e);
        exp_t x;
        x.sel = 2'(j);
        x.o   = pat(W_A[j], M_A[j], midx[j]);
        x.p   = 3'(midx[j]);
        x.w   = w;
        x.e   = e;
        return x;
    endfunction

    task automatic step(input int sel, input bit r, input bit e, input bit d, input bit l,
                        input int li, input bit corrupt, input string tag);
        exp_t x;
        int   k, ns;
        logic wr, er;
        logic [7:0] o;
        logic [2:0] p;
        logic       w, ef;
        @(negedge clk);
        reset    = r;
        dir      = d;
        load_idx = li[2:0];
        en       = '0;
        ld       = '0;
        en[sel]  = e;
        ld[sel]  = l;
        if (corrupt) force u0.out = 8'h03;
        if (r) begin
            for (int j = 0; j < 3; j++) begin
                midx[j] = RP_A[j];
                sb.push_back(mk(j, 1'b0, 1'b0));
            end
        end else begin
            k  = midx[sel];
            ns = ns_of(sel);
            wr = 1'b0;
            er = 1'b0;
            if (corrupt) begin
                k  = RP_A[sel];
                er = 1'b1;
            end else if (l) begin
                if (li < ns) k = li;
                else er = 1'b1;
            end else if (e) begin
                if (d) begin
                    wr = (k == ns - 1);
                    k  = (k + 1) % ns;
                end else begin
                    wr = (k == 0);
                    k  = (k + ns - 1) % ns;
                end
            end
            midx[sel] = k;
            sb.push_back(mk(sel, wr, er));
        end
        @(posedge clk);
        #1;
        if (corrupt) begin
            release u0.out;
            #1;
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.sel)
                2'd0:    begin o = out0;         p = pos0; w = wrap0; ef = err0; end
                2'd1:    begin o = {4'b0, out1}; p = pos1; w = wrap1; ef = err1; end
                default: begin o = {3'b0, out2}; p = pos2; w = wrap2; ef = err2; end
            endcase
            check($sformatf("%s[u%0d].out", tag, x.sel), 32'(o), 32'(x.o));
            check($sformatf("%s[u%0d].pos", tag, x.sel), 32'(p), 32'(x.p));
            check($sformatf("%s[u%0d].wrap", tag, x.sel), 32'(w), 32'(x.w));
            check($sformatf("%s[u%0d].err", tag, x.sel), 32'(ef), 32'(x.e));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 1, 0, 1, 0, 0, 0, "reset");
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0, 0, "oh_up");

        step(0, 1, 0, 1, 0, 0, 0, "reset2");
        step(0, 0, 1, 0, 0, 0, 0, "oh_down_wrap");
        step(0, 0, 1, 0, 0, 0, 0, "oh_down");

        for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 0, 0, 0, "jn_up");
        step(1, 0, 1, 0, 0, 0, 0, "jn_down_wrap");
        step(1, 0, 1, 0, 0, 0, 0, "jn_down");
        step(1, 0, 1, 1, 1, 6, 0, "jn_load6");
        step(1, 0, 1, 1, 0, 0, 0, "jn_up_after_load");

        step(0, 0, 1, 1, 1, 5, 0, "oh_load5");
        step(0, 0, 0, 1, 0, 0, 0, "oh_hold");

        step(2, 0, 1, 1, 1, 6, 0, "w5_badload");
        step(2, 0, 0, 1, 0, 0, 0, "w5_idle");
        step(2, 0, 1, 1, 1, 4, 0, "w5_load4");
        step(2, 0, 1, 1, 0, 0, 0, "w5_up_wrap");
        step(2, 0, 1, 0, 0, 0, 0, "w5_down_wrap");
        step(2, 0, 1, 0, 0, 0, 0, "w5_down");

        step(0, 0, 1, 1, 1, 3, 1, "oh_recover");
        step(0, 0, 1, 1, 0, 0, 0, "oh_resume1");
        step(0, 0, 1, 1, 0, 0, 0, "oh_resume2");

        step(0, 0, 1, 1, 0, 0, 0, "oh_pre_rst");
        step(0, 1, 1, 1, 1, 5, 0, "rst_override");
        step(0, 0, 1, 1, 0, 0, 0, "oh_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
